sdram_init_checker: RTL
=======================

# sdram_init_checker

Bus-side responder/checker for the SDRAM initialization sequence. Samples the controller's command bus {CS_n, RAS_n, CAS_n, WE_n} and address on every sdram_clk edge. Verifies the power-up wait, PRECHARGE-all, the minimum AUTO-REFRESH count, LOAD MODE REGISTER and the tRP/tRFC/tMRD gaps, then decodes and holds the mode register. Sits beside the SDRAM model/pins in simulation and FPGA debug builds; its outputs gate traffic checkers and report protocol errors.

## Interface
- ADDR_BITS, 12, address width (A11..A0)
- WAIT100, 13333, minimum cycles from reset release to first non-NOP command
- T_RP, 3, minimum cycles PRE -> next command
- T_RFC, 9, minimum cycles AREF -> next command
- T_MRD, 2, minimum cycles LMR -> init_ok
- MIN_AREF, 2, minimum AUTO-REFRESH commands before LMR
---
- sdram_clk  in  1  SDRAM clock; sole clock
- rst  in  1  asynchronous, active-high reset
- cmd  in  4  {CS_n, RAS_n, CAS_n, WE_n}
- sdram_addr  in  ADDR_BITS  address bus
- init_ok  out  1  legal sequence complete; mode outputs valid
- err  out  1  sticky protocol error
- err_code  out  3  first error: 0 none, 1 EARLY, 2 ORDER, 3 GAP, 4 PRE_A10, 5 MODE, 6 AREF_CNT
- bl_code  out  3  mode A2:A0
- burst_type  out  1  mode A3 (0 sequential)
- cas_lat  out  3  mode A6:A4
- wb_single  out  1  mode A9
- aref_cnt  out  4  AUTO-REFRESH commands counted, saturates at 15

## Operation
- Command decode: CS_n=1 -> NOP (deselect); 0111 NOP, 0010 PRE, 0001 AREF, 0000 LMR; any other code (ACT/RD/WR/BST) is "other".
- States: PWRUP -> WAIT_PRE -> TRP -> REFRESH -> TRFC -> (REFRESH | TMRD) -> DONE; ERR absorbing.
- PWRUP: counter counts from 0; any non-NOP while count < WAIT100 -> ERR/EARLY; at count = WAIT100 -> WAIT_PRE.
- WAIT_PRE: NOP stays. PRE with A10=1 -> TRP. PRE with A10=0 -> ERR/PRE_A10. AREF/LMR/other -> ERR/ORDER.
- TRP/TRFC: gap counter loaded on command. Non-NOP while elapsed < T_RP (resp. T_RFC) -> ERR/GAP. After the gap, the state accepts the next command in place.
- REFRESH phase (after TRP or TRFC gap): AREF increments aref_cnt and restarts the T_RFC gap. LMR with aref_cnt >= MIN_AREF -> TMRD. LMR with aref_cnt < MIN_AREF -> ERR/AREF_CNT. PRE/other -> ERR/ORDER.
- LMR capture: latch A2:A0, A3, A6:A4, A9 into mode outputs. Legal BL codes: 000, 001, 010, 011, and 111 only with A3=0. Legal CL codes: 010, 011. Any other value, or A8:A7 != 00, or A11:A10 != 00 -> ERR/MODE.
- TMRD: non-NOP before T_MRD elapsed -> ERR/GAP. Otherwise -> DONE.
- DONE: init_ok=1; all commands ignored; outputs held until reset.
- ERR: err=1; err_code holds the first error only; init_ok=0 permanently until reset.
- Reset (any time, mid-sequence included): all outputs 0, state PWRUP, counters 0.

## Timing
- Inputs sampled at posedge sdram_clk; all outputs registered.
- Gap rule: command sampled at edge k permits the next non-NOP at edge k+T (T = T_RP/T_RFC). A command at edge k+T-1 is a GAP error.
- err/err_code rise on the edge that samples the offending command, visible the cycle after.
- Mode outputs update on the LMR sampling edge.
- init_ok rises on edge k+T_MRD for LMR at edge k.
- Simultaneous events: one command per cycle, so error classes are mutually exclusive per command. Priority is EARLY > GAP > ORDER > PRE_A10 > AREF_CNT > MODE.

## Configuration
- SDRAM_CHK_PWRUP_EN defined: PWRUP state and WAIT100 counter are present and enforced as above.
- Undefined: counter removed; reset leaves directly to WAIT_PRE, and EARLY can never occur. Used for short simulations.

## Structure
- Package sdram_chk_pkg holds:
  - command encodings (NOP/PRE/AREF/LMR)
  - state encoding
  - err_code constants
  - legal BL/CL code constants
- Sub-module sdram_mode_dec: combinational mode-register field extraction and legality check, fed by sdram_addr, returning fields plus a mode_bad flag.

## Test plan
- Legal sequence: NOP to count 13333, PRE (A10=1) at 13334, AREF at +3, AREF at +12, LMR 12'h032 at +21 -> init_ok high 2 cycles after LMR; bl_code=010, burst_type=0, cas_lat=011, wb_single=0, aref_cnt=2, err=0.
- AREF 2 cycles after PRE (T_RP=3) -> err=1, err_code=3, init_ok stays 0; later legal commands do not change err_code.
- LMR after a single AREF -> err_code=6.
- LMR with address 12'h042 (CL=100) -> err_code=5.
- PRE at cycle 100 after reset -> err_code=1; with SDRAM_CHK_PWRUP_EN undefined the same PRE is accepted.
- Assert rst in TRFC -> all outputs 0 on the following cycle; a full legal sequence afterwards completes with init_ok=1.

Source files
------------

// File: rtl/sdram_chk_pkg.sv
// Shared encodings for the SDRAM init-sequence checker: bus commands, FSM states,
// error codes and the legal burst-length / CAS-latency codes.
package sdram_chk_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    KIND_NOP,
    KIND_PRE,
    KIND_AREF,
    KIND_LMR,
    KIND_OTHER
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_WAIT_PRE,
    ST_TRP,
    ST_REFRESH,
    ST_TRFC,
    ST_TMRD,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_EARLY    = 3'd1;
  localparam logic [2:0] ERR_ORDER    = 3'd2;
  localparam logic [2:0] ERR_GAP      = 3'd3;
  localparam logic [2:0] ERR_PRE_A10  = 3'd4;
  localparam logic [2:0] ERR_MODE     = 3'd5;
  localparam logic [2:0] ERR_AREF_CNT = 3'd6;

  localparam logic [2:0] BL_1    = 3'b000;
  localparam logic [2:0] BL_2    = 3'b001;
  localparam logic [2:0] BL_4    = 3'b010;
  localparam logic [2:0] BL_8    = 3'b011;
  localparam logic [2:0] BL_PAGE = 3'b111;

  localparam logic [2:0] CL_2 = 3'b010;
  localparam logic [2:0] CL_3 = 3'b011;

  // A deselected bus (CS_n high) is treated exactly like an explicit NOP.
  function automatic cmd_kind_e decode_cmd(input logic [3:0] c);
    cmd_kind_e k;
    if (c[3]) begin
      k = KIND_NOP;
    end else begin
      case (c)
        CMD_NOP:  k = KIND_NOP;
        CMD_PRE:  k = KIND_PRE;
        CMD_AREF: k = KIND_AREF;
        CMD_LMR:  k = KIND_LMR;
        default:  k = KIND_OTHER;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/sdram_mode_dec.sv
// Combinational mode-register decode: splits the LMR address into its fields and
// flags any burst-length, CAS-latency or reserved-bit combination we do not support.
module sdram_mode_dec
  import sdram_chk_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic [ADDR_BITS-1:0] addr_i,
  output logic [2:0]           bl_code_o,
  output logic                 burst_type_o,
  output logic [2:0]           cas_lat_o,
  output logic                 wb_single_o,
  output logic                 mode_bad_o
);

  logic blOk;
  logic clOk;
  logic rsvdOk;

  // Full-page burst is only meaningful with sequential ordering.
  always_comb begin
    bl_code_o    = addr_i[2:0];
    burst_type_o = addr_i[3];
    cas_lat_o    = addr_i[6:4];
    wb_single_o  = addr_i[9];

    case (addr_i[2:0])
      BL_1, BL_2, BL_4, BL_8: blOk = 1'b1;
      BL_PAGE:                blOk = ~addr_i[3];
      default:                blOk = 1'b0;
    endcase

    clOk       = (addr_i[6:4] == CL_2) || (addr_i[6:4] == CL_3);
    rsvdOk     = (addr_i[8:7] == 2'b00) && (addr_i[ADDR_BITS-1:10] == '0);
    mode_bad_o = ~(blOk & clOk & rsvdOk);
  end

endmodule

// File: rtl/sdram_init_checker.sv
// Bus-side checker for the SDRAM power-up / PRE / AREF / LMR init sequence.
// Define SDRAM_CHK_PWRUP_EN to enforce the WAIT100 power-up quiet period.
module sdram_init_checker
  import sdram_chk_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int WAIT100   = 13333,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 9,
  parameter int T_MRD     = 2,
  parameter int MIN_AREF  = 2
) (
  input  logic                 sdram_clk,
  input  logic                 rst,
  input  logic [3:0]           cmd,
  input  logic [ADDR_BITS-1:0] sdram_addr,
  output logic                 init_ok,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [2:0]           bl_code,
  output logic                 burst_type,
  output logic [2:0]           cas_lat,
  output logic                 wb_single,
  output logic [3:0]           aref_cnt
);

  localparam int GapW = 16;
  localparam logic [GapW-1:0] TRpV  = GapW'(T_RP);
  localparam logic [GapW-1:0] TRfcV = GapW'(T_RFC);
  localparam logic [GapW-1:0] TMrdV = GapW'(T_MRD);
  localparam logic [4:0]      MinArefV = 5'(MIN_AREF);

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      aref_q, aref_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            err_q, err_d;
  logic            init_ok_q, init_ok_d;
  logic [2:0]      bl_q, bl_d;
  logic            bt_q, bt_d;
  logic [2:0]      cl_q, cl_d;
  logic            wb_q, wb_d;

  cmd_kind_e  cmdKind;
  logic       pwrupDone;
  logic       preRules;
  logic       refreshRules;
  logic       fail;
  logic [2:0] failCode;
  logic [2:0] decBl;
  logic       decBt;
  logic [2:0] decCl;
  logic       decWb;
  logic       modeBad;

  assign cmdKind = decode_cmd(cmd);

`ifdef SDRAM_CHK_PWRUP_EN
  localparam int PwrW = $clog2(WAIT100 + 1) + 1;
  localparam logic [PwrW-1:0] WaitV = PwrW'(WAIT100);
  localparam state_e ResetState = ST_PWRUP;

  logic [PwrW-1:0] pwr_q, pwr_d;

  assign pwrupDone = (pwr_q >= WaitV);
  assign pwr_d     = ((state_q == ST_PWRUP) && !pwrupDone) ? pwr_q + 1'b1 : pwr_q;

  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      pwr_q <= '0;
    end else begin
      pwr_q <= pwr_d;
    end
  end
`else
  localparam state_e ResetState = ST_WAIT_PRE;

  // No quiet period in this build: the power-up state is never entered.
  assign pwrupDone = (WAIT100 >= 0);
`endif

  sdram_mode_dec #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mode_dec (
    .addr_i       (sdram_addr),
    .bl_code_o    (decBl),
    .burst_type_o (decBt),
    .cas_lat_o    (decCl),
    .wb_single_o  (decWb),
    .mode_bad_o   (modeBad)
  );

  // Once a gap has elapsed, TRP/TRFC take the next command in place using the refresh-phase rules.
  always_comb begin
    state_d      = state_q;
    gap_d        = (gap_q == '1) ? gap_q : gap_q + 1'b1;
    aref_d       = aref_q;
    err_code_d   = err_code_q;
    bl_d         = bl_q;
    bt_d         = bt_q;
    cl_d         = cl_q;
    wb_d         = wb_q;
    preRules     = 1'b0;
    refreshRules = 1'b0;
    fail         = 1'b0;
    failCode     = ERR_NONE;

    case (state_q)
      ST_PWRUP: begin
        if (!pwrupDone) begin
          if (cmdKind != KIND_NOP) begin
            fail     = 1'b1;
            failCode = ERR_EARLY;
          end
        end else begin
          preRules = 1'b1;
        end
      end
      ST_WAIT_PRE: preRules = 1'b1;
      ST_TRP: begin
        if (gap_q < TRpV) begin
          if (cmdKind != KIND_NOP) begin
            fail     = 1'b1;
            failCode = ERR_GAP;
          end
        end else begin
          refreshRules = 1'b1;
        end
      end
      ST_TRFC: begin
        if (gap_q < TRfcV) begin
          if (cmdKind != KIND_NOP) begin
            fail     = 1'b1;
            failCode = ERR_GAP;
          end
        end else begin
          refreshRules = 1'b1;
        end
      end
      ST_REFRESH: refreshRules = 1'b1;
      ST_TMRD: begin
        if (gap_q < TMrdV) begin
          if (cmdKind != KIND_NOP) begin
            fail     = 1'b1;
            failCode = ERR_GAP;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    if (preRules) begin
      case (cmdKind)
        KIND_NOP: state_d = ST_WAIT_PRE;
        KIND_PRE: begin
          if (sdram_addr[10]) begin
            state_d = ST_TRP;
            gap_d   = GapW'(1);
          end else begin
            fail     = 1'b1;
            failCode = ERR_PRE_A10;
          end
        end
        default: begin
          fail     = 1'b1;
          failCode = ERR_ORDER;
        end
      endcase
    end

    if (refreshRules) begin
      case (cmdKind)
        KIND_NOP: state_d = ST_REFRESH;
        KIND_AREF: begin
          state_d = ST_TRFC;
          gap_d   = GapW'(1);
          aref_d  = (aref_q == 4'hF) ? aref_q : aref_q + 4'd1;
        end
        KIND_LMR: begin
          if ({1'b0, aref_q} < MinArefV) begin
            fail     = 1'b1;
            failCode = ERR_AREF_CNT;
          end else begin
            bl_d = decBl;
            bt_d = decBt;
            cl_d = decCl;
            wb_d = decWb;
            if (modeBad) begin
              fail     = 1'b1;
              failCode = ERR_MODE;
            end else begin
              state_d = ST_TMRD;
              gap_d   = GapW'(1);
            end
          end
        end
        default: begin
          fail     = 1'b1;
          failCode = ERR_ORDER;
        end
      endcase
    end

    if (fail) begin
      state_d    = ST_ERR;
      err_code_d = failCode;
    end

    init_ok_d = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ResetState;
      gap_q      <= '0;
      aref_q     <= '0;
      err_code_q <= ERR_NONE;
      err_q      <= 1'b0;
      init_ok_q  <= 1'b0;
      bl_q       <= '0;
      bt_q       <= 1'b0;
      cl_q       <= '0;
      wb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      aref_q     <= aref_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      init_ok_q  <= init_ok_d;
      bl_q       <= bl_d;
      bt_q       <= bt_d;
      cl_q       <= cl_d;
      wb_q       <= wb_d;
    end
  end

  assign init_ok    = init_ok_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign bl_code    = bl_q;
  assign burst_type = bt_q;
  assign cas_lat    = cl_q;
  assign wb_single  = wb_q;
  assign aref_cnt   = aref_q;

endmodule
